// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial link: bit-order selectors and the
// output-stage state type used by the receiver.
package serial_deser_pkg;

  // Bit order on the wire; the transmitter uses the same encoding.
  localparam int DIR_LSB_FIRST = 0;
  localparam int DIR_MSB_FIRST = 1;

  // Output holding stage: empty, or holding one unconsumed word.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/serial_deser_out_stage.sv
// One-word valid/ready holding stage for the deserializer. A completed
// word is accepted when the stage is empty or is being drained on the same
// edge. Otherwise the new word is dropped and the sticky overrun flag is set.
module deser_out_stage
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             m_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             overrun
);

  out_state_t       state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic             overrun_reg;
  logic             load;
  logic             set_ovr;

  // State register for the holding-stage FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= OUT_EMPTY;
    else     state_reg <= state_next;
  end

  // Next state, word load and overrun detection.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    set_ovr    = 1'b0;
    case (state_reg)
      OUT_EMPTY: begin
        if (word_done) begin
          load       = 1'b1;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (word_done) begin
          // Drained and refilled on the same edge: no bubble.
          if (m_ready) load    = 1'b1;
          else         set_ovr = 1'b1;
        end else if (m_ready) begin
          state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Word register; it only changes on a load, so it is stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_reg <= '0;
    else if (load) data_reg <= word;
  end

  // Sticky overrun flag. A set on the same edge as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun_reg <= 1'b0;
    else if (set_ovr) overrun_reg <= 1'b1;
    else if (ovr_clr) overrun_reg <= 1'b0;
  end

  assign m_data  = data_reg;
  assign m_valid = (state_reg == OUT_FULL);
  assign overrun = overrun_reg;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver. Qualified bits are shifted into a word
// register. On the WIDTH-th bit, the completed word (including that bit)
// goes straight into the one-word output stage. A sync strobe realigns the
// word boundary.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIR   = DIR_LSB_FIRST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     sync,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shifted;  // sr_reg with bit_in shifted in
  logic [WIDTH-1:0] fresh;    // bit_in as the first bit of an empty word
  logic             word_done;

  // Bit order is fixed at elaboration. The first received bit always ends
  // up at the position the transmitter shifted it out of.
  generate
    if (DIR == DIR_LSB_FIRST) begin : g_lsb_first
      assign shifted = {bit_in, sr_reg[WIDTH-1:1]};
      assign fresh   = {bit_in, {(WIDTH-1){1'b0}}};
    end else begin : g_msb_first
      assign shifted = {sr_reg[WIDTH-2:0], bit_in};
      assign fresh   = {{(WIDTH-1){1'b0}}, bit_in};
    end
  endgenerate

  // Next shift-register and counter values, and word-completion detection.
  always_comb begin
    sr_next   = sr_reg;
    cnt_next  = cnt_reg;
    word_done = 1'b0;
    if (bit_valid) begin
      if (sync) begin
        // Discard the partial word; this bit starts a new one.
        sr_next  = fresh;
        cnt_next = CW'(1);
      end else begin
        sr_next = shifted;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          cnt_next  = '0;
          word_done = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  // Shift register and bit counter. These never stall on back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_next;
    end
  end

  assign bit_cnt = cnt_reg;

  deser_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .word      (sr_next),
    .word_done (word_done),
    .m_ready   (m_ready),
    .ovr_clr   (ovr_clr),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser. An LSB-first and an MSB-first instance
// share the same stimulus. Each step checks the instance whose bit order it
// targets.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_valid, sync, m_ready, ovr_clr;
  logic [7:0] data_l, data_m;
  logic       valid_l, valid_m, ovr_l, ovr_m;
  logic [2:0] cnt_l, cnt_m;

  int checks = 0;
  int errors = 0;

  serial_deser #(.WIDTH(8), .DIR(0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .m_data(data_l), .m_valid(valid_l), .m_ready(m_ready), .overrun(ovr_l),
    .ovr_clr(ovr_clr), .bit_cnt(cnt_l)
  );

  serial_deser #(.WIDTH(8), .DIR(1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .m_data(data_m), .m_valid(valid_m), .m_ready(m_ready), .overrun(ovr_m),
    .ovr_clr(ovr_clr), .bit_cnt(cnt_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one qualified bit for exactly one edge, then sample at edge+1.
  task automatic send_bit(input logic b, input logic s);
    bit_in    = b;
    bit_valid = 1'b1;
    sync      = s;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Send a byte as eight consecutive bits, LSB-first or MSB-first.
  task automatic send_word(input logic [7:0] w, input logic msb_first);
    for (int i = 0; i < 8; i++)
      send_bit(msb_first ? w[7-i] : w[i], 1'b0);
  endtask

  logic [7:0] pattern;
  logic [7:0] tx;
  logic [7:0] w;
  int         cyc, pulses, spurious;
  int         pulse_cyc [3];
  logic [7:0] pulse_dat [3];

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0;
    m_ready = 1'b1; ovr_clr = 1'b0;
    #1;
    check("rst_m_data",  data_l,  8'h00);
    check("rst_m_valid", valid_l, 1'b0);
    check("rst_overrun", ovr_l,   1'b0);
    check("rst_bit_cnt", cnt_l,   3'd0);
    @(negedge clk); rst = 1'b0;
    idle_cycle();

    // Bits 1,0,1,1,0,0,1,0 in order: 0x4D LSB-first, 0xB2 MSB-first.
    pattern = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send_bit(pattern[i], 1'b0);
      if (i == 2) check("cnt_after_3", cnt_l, 3'd3);
      if (i < 7)  check("no_early_valid", valid_l, 1'b0);
    end
    check("lsb_data",  data_l,  8'h4D);
    check("lsb_valid", valid_l, 1'b1);
    check("msb_data",  data_m,  8'hB2);
    check("cnt_wrap",  cnt_l,   3'd0);
    idle_cycle();
    check("valid_one_cycle", valid_l, 1'b0);

    // Same bits with idle gaps; the counter holds through each gap.
    for (int i = 0; i < 8; i++) begin
      send_bit(pattern[i], 1'b0);
      idle_cycle();
      if (i == 3) check("cnt_hold_gap", cnt_l, 3'd4);
    end
    check("gap_msb_data", data_m, 8'hB2);
    check("gap_lsb_data", data_l, 8'h4D);
    idle_cycle();

    // Loopback from a shift-right transmitter (serial_out = sr[0]).
    tx = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_bit(tx[0], 1'b0);
      tx = {1'b0, tx[7:1]};
    end
    check("loop_lsb_a5", data_l, 8'hA5);
    idle_cycle();
    // Loopback from a shift-left transmitter (serial_out = sr[7]).
    tx = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      send_bit(tx[7], 1'b0);
      tx = {tx[6:0], 1'b0};
    end
    check("loop_msb_3c", data_m, 8'h3C);
    idle_cycle();

    // Back-pressure: the second word is dropped and overrun is set.
    m_ready = 1'b0;
    send_word(8'h11, 1'b0);
    check("bp_first_valid", valid_l, 1'b1);
    check("bp_first_data",  data_l,  8'h11);
    check("bp_no_ovr_yet",  ovr_l,   1'b0);
    send_word(8'h22, 1'b0);
    check("bp_data_kept",   data_l,  8'h11);
    check("bp_overrun",     ovr_l,   1'b1);
    m_ready = 1'b1;
    idle_cycle();
    m_ready = 1'b0;
    check("bp_drained",     valid_l, 1'b0);
    check("bp_ovr_sticky",  ovr_l,   1'b1);
    ovr_clr = 1'b1;
    idle_cycle();
    ovr_clr = 1'b0;
    check("ovr_cleared",    ovr_l,   1'b0);
    send_word(8'h33, 1'b0);
    check("bp_load_33",     data_l,  8'h33);
    ovr_clr = 1'b1;  // held across the overrunning completion edge
    send_word(8'h44, 1'b0);
    ovr_clr = 1'b0;
    check("ovr_set_wins",   ovr_l,   1'b1);
    check("bp_keep_33",     data_l,  8'h33);
    m_ready = 1'b1; ovr_clr = 1'b1;
    idle_cycle();
    ovr_clr = 1'b0;
    check("bp_final_empty", valid_l, 1'b0);
    check("bp_final_clr",   ovr_l,   1'b0);

    // Sync after three stray bits realigns the word boundary.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    w = 8'hC3;
    spurious = 0;
    send_bit(w[0], 1'b1);
    check("sync_cnt", cnt_l, 3'd1);
    for (int i = 1; i < 8; i++) begin
      if (valid_l) spurious++;
      send_bit(w[i], 1'b0);
    end
    check("sync_no_spurious", spurious, 0);
    check("sync_data",  data_l,  8'hC3);
    check("sync_valid", valid_l, 1'b1);
    idle_cycle();

    // Async reset mid-word with a held word: outputs clear before any edge.
    m_ready = 1'b0;
    send_word(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_m_data",  data_l,  8'h00);
    check("arst_m_valid", valid_l, 1'b0);
    check("arst_bit_cnt", cnt_l,   3'd0);
    check("arst_overrun", ovr_l,   1'b0);
    @(negedge clk); rst = 1'b0;
    idle_cycle();
    m_ready = 1'b1;
    send_word(8'h96, 1'b0);
    check("post_rst_data",  data_l,  8'h96);
    check("post_rst_valid", valid_l, 1'b1);
    idle_cycle();

    // Back-to-back words 0x01..0x03 with no gaps.
    cyc = 0; pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      w = 8'(k);
      for (int i = 0; i < 8; i++) begin
        send_bit(w[i], 1'b0);
        cyc++;
        if (valid_l) begin
          if (pulses < 3) begin
            pulse_cyc[pulses] = cyc;
            pulse_dat[pulses] = data_l;
          end
          pulses++;
        end
      end
    end
    check("b2b_pulses", pulses, 3);
    if (pulses == 3) begin
      check("b2b_gap1",  pulse_cyc[1] - pulse_cyc[0], 8);
      check("b2b_gap2",  pulse_cyc[2] - pulse_cyc[1], 8);
      check("b2b_word1", pulse_dat[0], 8'h01);
      check("b2b_word2", pulse_dat[1], 8'h02);
      check("b2b_word3", pulse_dat[2], 8'h03);
    end
    check("b2b_overrun", ovr_l, 1'b0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
